// File: rtl/lm_sm_sequencer_if.sv
// Decoder <-> LM/SM sequencer bundle: instruction request in, micro-op stream and freeze out.
interface lm_sm_sequencer_if #(
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned REG_IDX_W = 3,
    parameter int unsigned OFS_W     = 4
);
    logic                 start;
    logic                 is_lm;
    logic [NUM_REGS-1:0]  imm_mask;
    logic                 stall_in;
    logic                 flush;
    logic                 uop_valid;
    logic [REG_IDX_W-1:0] uop_reg;
    logic [OFS_W-1:0]     uop_ofs;
    logic [1:0]           uop_regdst;
    logic                 uop_reg_write;
    logic                 uop_mem_write;
    logic                 uop_last;
    logic                 stall_fetch;
    logic                 busy;
    logic                 done;

    modport master (
        output start, is_lm, imm_mask, stall_in, flush,
        input  uop_valid, uop_reg, uop_ofs, uop_regdst, uop_reg_write,
               uop_mem_write, uop_last, stall_fetch, busy, done
    );

    modport slave (
        input  start, is_lm, imm_mask, stall_in, flush,
        output uop_valid, uop_reg, uop_ofs, uop_regdst, uop_reg_write,
               uop_mem_write, uop_last, stall_fetch, busy, done
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM instruction into one memory micro-op per set mask bit, R0 first,
// freezing fetch/decode until the last micro-op is presented.
module lm_sm_sequencer #(
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned REG_IDX_W = 3,
    parameter int unsigned OFS_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    lm_sm_sequencer_if.slave    bus
);
    typedef enum logic {IDLE, SEQ} state_e;

    state_e                state_q;
    logic [NUM_REGS-1:0]   mask_q;
    logic [OFS_W-1:0]      ofs_q;
    logic                  lm_q;
    logic                  done_q;

    logic [NUM_REGS-1:0]   mask_d;
    logic [REG_IDX_W-1:0]  sel_idx;
    logic                  single_bit;
    logic                  in_seq;
    logic                  req_nonempty;

    // Lowest set bit of the pending mask selects the current register.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask_q[i]) sel_idx = REG_IDX_W'(i);
        end
    end

    // x & (x-1) drops the lowest set bit; empty result means this is the last micro-op.
    assign mask_d       = mask_q & (mask_q - NUM_REGS'(1));
    assign single_bit   = (mask_q != '0) && (mask_d == '0);
    assign in_seq       = (state_q == SEQ);
    assign req_nonempty = (state_q == IDLE) && bus.start && (bus.imm_mask != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ofs_q   <= '0;
            lm_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state_q <= IDLE;
                mask_q  <= '0;
                ofs_q   <= '0;
                lm_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if (bus.imm_mask != '0) begin
                                state_q <= SEQ;
                                mask_q  <= bus.imm_mask;
                                lm_q    <= bus.is_lm;
                                ofs_q   <= '0;
                            end else begin
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    SEQ: begin
                        if (!bus.stall_in) begin
                            mask_q <= mask_d;
                            ofs_q  <= ofs_q + OFS_W'(1);
                            if (single_bit) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.uop_valid     = in_seq;
    assign bus.uop_reg       = in_seq ? sel_idx : '0;
    assign bus.uop_ofs       = ofs_q;
    assign bus.uop_regdst    = (in_seq && lm_q) ? 2'b11 : 2'b00;
    assign bus.uop_reg_write = in_seq && lm_q;
    assign bus.uop_mem_write = in_seq && !lm_q;
    assign bus.uop_last      = in_seq && single_bit;
    assign bus.stall_fetch   = req_nonempty || (in_seq && !single_bit);
    assign bus.busy          = in_seq;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Vector-driven bench for lm_sm_sequencer with a micro-op scoreboard.
module tb_lm_sm_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lm_sm_sequencer_if bus ();
    lm_sm_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic       start;
        logic       is_lm;
        logic [7:0] mask;
        logic       stall;
        logic       flush;
        logic       exp_sf;
        logic       exp_done;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        logic [2:0] r;
        logic [3:0] ofs;
        logic       lm;
        logic       last;
    } uop_t;

    vec_t vecs[$];
    uop_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int s, input int lm, input logic [7:0] m, input int st,
                       input int fl, input int sf, input int dn, input int bz);
        vec_t v;
        v.start = (s != 0);   v.is_lm = (lm != 0); v.mask = m;
        v.stall = (st != 0);  v.flush = (fl != 0);
        v.exp_sf = (sf != 0); v.exp_done = (dn != 0); v.exp_busy = (bz != 0);
        vecs.push_back(v);
    endtask

    // Expected micro-ops of an accepted instruction, in ascending register order.
    task automatic push_seq(input logic lm, input logic [7:0] m);
        uop_t u;
        int   n;
        int   k;
        n = $countones(m);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                u.r = 3'(i); u.ofs = 4'(k); u.lm = lm; u.last = (k == n - 1);
                sb.push_back(u);
                k++;
            end
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        uop_t e;
        @(negedge clk);
        bus.start = v.start; bus.is_lm = v.is_lm; bus.imm_mask = v.mask;
        bus.stall_in = v.stall; bus.flush = v.flush;
        #4;
        chk({tag, " stall_fetch"}, 32'(bus.stall_fetch), 32'(v.exp_sf));
        chk({tag, " done"},        32'(bus.done),        32'(v.exp_done));
        chk({tag, " busy"},        32'(bus.busy),        32'(v.exp_busy));
        chk({tag, " uop_valid"},   32'(bus.uop_valid),   32'(v.exp_busy));
        if (v.start && v.mask != 8'h00 && !v.flush && !v.exp_busy) push_seq(v.is_lm, v.mask);
        if (bus.uop_valid) begin
            if (sb.size() == 0) begin
                chk({tag, " sb_pending"}, 32'(sb.size()), 32'd1);
            end else begin
                e = sb[0];
                chk({tag, " uop_reg"},       32'(bus.uop_reg),       32'(e.r));
                chk({tag, " uop_ofs"},       32'(bus.uop_ofs),       32'(e.ofs));
                chk({tag, " uop_regdst"},    32'(bus.uop_regdst),    e.lm ? 32'd3 : 32'd0);
                chk({tag, " uop_reg_write"}, 32'(bus.uop_reg_write), 32'(e.lm));
                chk({tag, " uop_mem_write"}, 32'(bus.uop_mem_write), 32'(!e.lm));
                chk({tag, " uop_last"},      32'(bus.uop_last),      32'(e.last));
                if (v.flush) sb.delete();
                else if (!v.stall) void'(sb.pop_front());
            end
        end
    endtask

    task automatic run(input string name);
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("%s[%0d]", name, i));
        vecs.delete();
        chk({name, " sb_drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1;
        bus.start = 1'b0; bus.is_lm = 1'b0; bus.imm_mask = 8'h00;
        bus.stall_in = 1'b0; bus.flush = 1'b0;
        #12;
        chk("reset uop_valid",   32'(bus.uop_valid),   32'd0);
        chk("reset busy",        32'(bus.busy),        32'd0);
        chk("reset stall_fetch", 32'(bus.stall_fetch), 32'd0);
        chk("reset done",        32'(bus.done),        32'd0);
        chk("reset uop_ofs",     32'(bus.uop_ofs),     32'd0);
        chk("reset uop_reg",     32'(bus.uop_reg),     32'd0);
        chk("reset uop_regdst",  32'(bus.uop_regdst),  32'd0);
        chk("reset uop_last",    32'(bus.uop_last),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LM 0xA5, plus a start during SEQ that must be ignored
        add(1,1,8'hA5,0,0, 1,0,0);
        add(0,0,8'h00,0,0, 1,0,1);
        add(1,0,8'hFF,0,0, 1,0,1);
        add(0,0,8'h00,0,0, 1,0,1);
        add(0,0,8'h00,0,0, 0,0,1);
        add(0,0,8'h00,0,0, 0,1,0);
        add(0,0,8'h00,0,0, 0,0,0);
        run("lm_a5");

        // SM 0xFF with stall held two cycles on R3
        add(1,0,8'hFF,0,0, 1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,8'h00,0,0, 1,0,1);
        add(0,0,8'h00,1,0, 1,0,1);
        add(0,0,8'h00,1,0, 1,0,1);
        for (int i = 0; i < 4; i++) add(0,0,8'h00,0,0, 1,0,1);
        add(0,0,8'h00,0,0, 0,0,1);
        add(0,0,8'h00,0,0, 0,1,0);
        run("sm_ff");
        chk("sm_ff final ofs", 32'(bus.uop_ofs), 32'd8);

        // Empty mask
        add(1,1,8'h00,0,0, 0,0,0);
        add(0,0,8'h00,0,0, 0,1,0);
        add(0,0,8'h00,0,0, 0,0,0);
        run("empty");

        // Flush on R1, then a single-bit LM
        add(1,1,8'h0F,0,0, 1,0,0);
        add(0,0,8'h00,0,0, 1,0,1);
        add(0,0,8'h00,0,1, 1,0,1);
        add(0,0,8'h00,0,0, 0,0,0);
        add(1,1,8'h80,0,0, 1,0,0);
        add(0,0,8'h00,0,0, 0,0,1);
        add(0,0,8'h00,0,0, 0,1,0);
        add(0,0,8'h00,0,0, 0,0,0);
        run("flush");

        // Async reset in the middle of the R2 micro-op of mask 0x1C
        v.start = 1'b1; v.is_lm = 1'b1; v.mask = 8'h1C; v.stall = 1'b0; v.flush = 1'b0;
        v.exp_sf = 1'b1; v.exp_done = 1'b0; v.exp_busy = 1'b0;
        step(v, "rst_start");
        @(negedge clk);
        bus.start = 1'b0; bus.imm_mask = 8'h00;
        #2;
        chk("rst pre valid", 32'(bus.uop_valid), 32'd1);
        chk("rst pre reg",   32'(bus.uop_reg),   32'd2);
        rst = 1'b1;
        #1;
        chk("rst mid valid",       32'(bus.uop_valid),     32'd0);
        chk("rst mid busy",        32'(bus.busy),          32'd0);
        chk("rst mid reg",         32'(bus.uop_reg),       32'd0);
        chk("rst mid ofs",         32'(bus.uop_ofs),       32'd0);
        chk("rst mid stall_fetch", 32'(bus.stall_fetch),   32'd0);
        chk("rst mid reg_write",   32'(bus.uop_reg_write), 32'd0);
        sb.delete();
        @(negedge clk);
        chk("rst held done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        add(1,0,8'h01,0,0, 1,0,0);
        add(0,0,8'h00,0,0, 0,0,1);
        add(0,0,8'h00,0,0, 0,1,0);
        run("post_rst");

        // Back-to-back: new start in the cycle after uop_last
        add(1,1,8'h03,0,0, 1,0,0);
        add(0,0,8'h00,0,0, 1,0,1);
        add(0,0,8'h00,0,0, 0,0,1);
        add(1,1,8'h40,0,0, 1,1,0);
        add(0,0,8'h00,0,0, 0,0,1);
        add(0,0,8'h00,0,0, 0,1,0);
        add(0,0,8'h00,0,0, 0,0,0);
        run("b2b");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Micro-op sequencer for the Load-Multiple / Store-Multiple (LM/SM) instructions in the 6-stage pipeline.
- Sits in the decode stage. Expands one LM/SM instruction with an 8-bit register mask into one memory micro-op per set bit.
- Drives the register index used by destination-register selection with RegDst=2'b11 (LM) or the store source index (SM), plus a word offset for address generation.
- Freezes fetch/decode while the expansion runs.

Parameters:
- NUM_REGS, 8, architectural register count; equals mask width; power of 2.
- REG_IDX_W, 3, register index width = log2(NUM_REGS).
- OFS_W, 4, word-offset counter width; must hold 0..NUM_REGS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  decoder presents an LM/SM instruction this cycle.
- is_lm  input  1  1 = LM (load to registers), 0 = SM (store from registers); sampled with start.
- imm_mask  input  NUM_REGS  register mask; bit i selects Ri; sampled with start.
- stall_in  input  1  downstream hazard freeze; holds the current micro-op.
- flush  input  1  pipeline flush from a later stage; kills the sequence.
- uop_valid  output  1  a micro-op is presented this cycle.
- uop_reg  output  REG_IDX_W  register index of the current micro-op (LM_reg for LM, store source for SM).
- uop_ofs  output  OFS_W  word offset from base address (0 for the first micro-op).
- uop_regdst  output  2  2'b11 for LM micro-ops, 2'b00 otherwise.
- uop_reg_write  output  1  uop_valid & LM.
- uop_mem_write  output  1  uop_valid & SM.
- uop_last  output  1  current micro-op is the final one of the sequence.
- stall_fetch  output  1  hold PC and the IF/ID register.
- busy  output  1  state == SEQ.
- done  output  1  one-cycle pulse when a sequence completes, or when an empty mask is accepted.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, pending mask=0, offset=0, lm flag=0, done=0. All uop_* outputs, busy and stall_fetch read 0.
- States: IDLE, SEQ. Pending mask, offset and lm flag are registers. uop_* outputs are combinational from these registers.
- IDLE, start=1, imm_mask!=0, flush=0:
  - Latch mask and is_lm; offset<=0; go to SEQ.
  - stall_fetch=1 combinationally in this cycle.
- IDLE, start=1, imm_mask==0:
  - Stay in IDLE; done=1 next cycle.
  - No micro-ops; stall_fetch stays 0.
- SEQ outputs:
  - uop_valid=1.
  - uop_reg = index of the lowest set bit of the pending mask (ascending order R0 to R7).
  - uop_ofs = offset.
  - uop_last = 1 when the pending mask has exactly one bit set.
- SEQ advance: on each edge with stall_in=0, clear the selected bit and increment offset.
  - If uop_last, go to IDLE and pulse done the next cycle.
  - stall_in=1 holds every register, so the micro-op is re-presented unchanged.
- stall_fetch = (IDLE & start & imm_mask!=0) | (SEQ & ~uop_last). It drops on the last micro-op cycle, so fetch resumes the following cycle.
- Latency: start accepted at edge N; micro-op k (0-based) is presented in cycle N+1+k with no stalls. An n-bit mask occupies n cycles in SEQ.
- flush has priority over start and stall_in.
  - From any state, the next edge goes to IDLE with mask and offset cleared; no done pulse.
  - flush together with start in IDLE: the instruction is not accepted.
- start while in SEQ is ignored; the decoder is frozen by stall_fetch.
- Offset never wraps: its maximum is NUM_REGS-1 while presented and NUM_REGS at exit.
- Reset asserted mid-sequence aborts immediately; no partial done.

Test Plan:
- LM, imm_mask=8'b1010_0101, no stalls -> uop_reg 0,2,5,7 on consecutive cycles; uop_ofs 0,1,2,3; uop_regdst=11 and uop_reg_write=1 on each; uop_last only on R7; stall_fetch high for start cycle plus 3 cycles; done pulses once.
- SM, imm_mask=8'hFF with stall_in=1 for 2 cycles on the R3 micro-op -> R3/ofs 3 held for 3 cycles total; uop_mem_write=1 and uop_reg_write=0 throughout; 8 distinct micro-ops R0..R7; final offset reaches 8 and the block returns to IDLE.
- imm_mask=8'h00 with start -> no uop_valid, stall_fetch=0, done=1 on the next cycle.
- LM, imm_mask=8'h0F; flush asserted on the R1 micro-op -> IDLE next cycle, uop_valid=0, no done; a new start with 8'h80 -> single micro-op R7, ofs 0, uop_last=1, stall_fetch=0.
- Async rst pulse mid-edge during the SEQ R2 micro-op of mask 8'h1C -> outputs zero immediately without a clock edge; after release, busy=0 and start is accepted normally.
- Back-to-back: start with 8'h03, then start with 8'h40 in the cycle after uop_last -> micro-ops R0, R1, then R6 with no bubble beyond one IDLE acceptance cycle.
